// File: rtl/hilo_unit_if.sv
// Handshake bundle between the HI/LO unit (initiator) and the external 32-bit divider.
// The divider has no reset, so its outputs may carry stale pulses at any time.
interface hilo_unit_if;
    logic        validIn;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        validOut;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport master (
        output validIn,
        output SrcA,
        output SrcB,
        input  validOut,
        input  Hi,
        input  Lo
    );

    modport slave (
        input  validIn,
        input  SrcA,
        input  SrcB,
        output validOut,
        output Hi,
        output Lo
    );
endinterface

// File: rtl/hilo_unit.sv
// MIPS HI/LO register unit: single-cycle multiplies, MT/MF moves and multi-cycle divides
// delegated to an external unsigned divider, with sign fix-up applied on completion.
module hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             stall,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    hilo_unit_if.master      div
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] srcA_q, srcA_d;
    logic [WIDTH-1:0] srcB_q, srcB_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic               accept;
    logic [2*WIDTH-1:0] prodS;
    logic [2*WIDTH-1:0] prodU;
    logic [WIDTH-1:0]   absRs;
    logic [WIDTH-1:0]   absRt;

    assign busy   = (state_q != IDLE);
    assign stall  = op_valid && busy;
    assign accept = op_valid && !busy;

    // Sign-extending to double width lets one unsigned multiplier give the exact signed product.
    assign prodS = {{WIDTH{rs_val[WIDTH-1]}}, rs_val} * {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
    assign prodU = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};

    // The most negative value negates to itself, which read as unsigned is the correct magnitude.
    assign absRs = rs_val[WIDTH-1] ? -rs_val : rs_val;
    assign absRt = rt_val[WIDTH-1] ? -rt_val : rt_val;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        srcA_d  = srcA_q;
        srcB_d  = srcB_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT:  {hi_d, lo_d} = prodS;
                        OP_MULTU: {hi_d, lo_d} = prodU;
                        OP_DIV, OP_DIVU: begin
                            if (rt_val != '0) begin
                                srcA_d  = (op == OP_DIV) ? absRs : rs_val;
                                srcB_d  = (op == OP_DIV) ? absRt : rt_val;
                                qneg_d  = (op == OP_DIV) && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                                rneg_d  = (op == OP_DIV) && rs_val[WIDTH-1];
                                state_d = LAUNCH;
                            end
                        end
                        OP_MTHI:  hi_d = rs_val;
                        OP_MTLO:  lo_d = rs_val;
                        default:  ;
                    endcase
                end
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                // Divider Hi is the quotient (goes to LO), Lo is the remainder (goes to HI).
                if (div.validOut) begin
                    lo_d    = qneg_q ? -div.Hi : div.Hi;
                    hi_d    = rneg_q ? -div.Lo : div.Lo;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            srcA_q  <= '0;
            srcB_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            srcA_q  <= srcA_d;
            srcB_q  <= srcB_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (op == OP_MFHI) begin
            rd_data = hi_q;
        end else if (op == OP_MFLO) begin
            rd_data = lo_q;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div.validIn = (state_q == LAUNCH);
    assign div.SrcA    = srcA_q;
    assign div.SrcB    = srcB_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Randomized bench for hilo_unit: a signed/unsigned arithmetic reference model plus an
// emulated divider with random latency that can also inject stale done pulses.
module tb_hilo_unit;

    localparam logic [2:0] MULT  = 3'd0;
    localparam logic [2:0] MULTU = 3'd1;
    localparam logic [2:0] DIV   = 3'd2;
    localparam logic [2:0] DIVU  = 3'd3;
    localparam logic [2:0] MTHI  = 3'd4;
    localparam logic [2:0] MTLO  = 3'd5;
    localparam logic [2:0] MFHI  = 3'd6;
    localparam logic [2:0] MFLO  = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        opValid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rsVal = '0;
    logic [31:0] rtVal = '0;
    logic        stall;
    logic [31:0] rdData;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    hilo_unit_if divBus();

    hilo_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (opValid),
        .op       (op),
        .rs_val   (rsVal),
        .rt_val   (rtVal),
        .stall    (stall),
        .rd_data  (rdData),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .div      (divBus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] expHi = '0;
    logic [31:0] expLo = '0;
    logic [31:0] expSrcA = '0;
    logic [31:0] expSrcB = '0;
    int          expLaunch = 0;
    int          launchCount = 0;
    int          dlyMin = 0;
    int          dlyMax = 4;
    bit          forceOut = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] magnitude(input logic [31:0] v);
        longint s;
        s = longint'($signed(v));
        if (s < 0) s = -s;
        return s[31:0];
    endfunction

    // Architectural effect of one accepted instruction, computed with plain integer arithmetic.
    task automatic modelOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        case (o)
            MULT: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                expHi = p[63:32];
                expLo = p[31:0];
            end
            MULTU: begin
                p = 64'(a) * 64'(b);
                expHi = p[63:32];
                expLo = p[31:0];
            end
            DIV: if (b != 0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa / sb;
                r  = sa % sb;
                expLo = q[31:0];
                expHi = r[31:0];
                expSrcA = magnitude(a);
                expSrcB = magnitude(b);
                expLaunch++;
            end
            DIVU: if (b != 0) begin
                expLo = a / b;
                expHi = a % b;
                expSrcA = a;
                expSrcB = b;
                expLaunch++;
            end
            MTHI: expHi = a;
            MTLO: expLo = a;
            default: ;
        endcase
    endtask

    // Called at a negedge; presents the op, rides out any stall, and returns at the negedge after acceptance.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output int stalled);
        bit launches;
        stalled = 0;
        opValid = 1'b1;
        op      = o;
        rsVal   = a;
        rtVal   = b;
        #1;
        while (stall && stalled < 100) begin
            @(negedge clk);
            #1;
            stalled++;
        end
        if (stalled >= 100) checkOutput("stallTimeout", 32'(stall), 32'd0);
        if (o == MFHI) checkOutput("mfhiData", rdData, expHi);
        else if (o == MFLO) checkOutput("mfloData", rdData, expLo);
        else checkOutput("rdDataZero", rdData, 32'd0);
        launches = ((o == DIV) || (o == DIVU)) && (b != 0);
        modelOp(o, a, b);
        @(posedge clk);
        @(negedge clk);
        opValid = 1'b0;
        op      = 3'($urandom);
        rsVal   = $urandom;
        rtVal   = $urandom;
        checkOutput("busyAfterAccept", 32'(busy), 32'(launches));
        checkOutput("validInAfterAccept", 32'(divBus.validIn), 32'(launches));
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput("busyTimeout", 32'(busy), 32'd0);
    endtask

    task automatic checkState();
        checkOutput("hi", hi, expHi);
        checkOutput("lo", lo, expLo);
        checkOutput("busyIdle", 32'(busy), 32'd0);
    endtask

    // Divider emulation: answers each launch after a random delay and keeps running through reset.
    initial begin : divider
        int          cnt;
        bit          pending;
        logic [31:0] a, b;
        cnt = 0;
        pending = 1'b0;
        a = '0;
        b = '1;
        divBus.validOut = 1'b0;
        divBus.Hi = '0;
        divBus.Lo = '0;
        forever begin
            @(negedge clk);
            divBus.validOut = 1'b0;
            if (forceOut) begin
                divBus.validOut = 1'b1;
                divBus.Hi = $urandom;
                divBus.Lo = $urandom;
                forceOut = 1'b0;
            end else if (pending) begin
                if (cnt == 0) begin
                    divBus.validOut = 1'b1;
                    divBus.Hi = (b != 0) ? a / b : '1;
                    divBus.Lo = (b != 0) ? a % b : '1;
                    pending = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (divBus.validIn === 1'b1) begin
                pending = 1'b1;
                a = divBus.SrcA;
                b = divBus.SrcB;
                cnt = int'($urandom_range(dlyMax, dlyMin));
                launchCount++;
            end
            if (busy === 1'b1) begin
                checkOutput("srcAHeld", divBus.SrcA, expSrcA);
                checkOutput("srcBHeld", divBus.SrcB, expSrcB);
            end
        end
    end

    initial begin : main
        int st;
        int l0;
        logic [2:0]  o;
        logic [31:0] a, b;

        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rstHi", hi, 32'd0);
        checkOutput("rstLo", lo, 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstValidIn", 32'(divBus.validIn), 32'd0);
        checkOutput("rstSrcA", divBus.SrcA, 32'd0);
        checkOutput("rstSrcB", divBus.SrcB, 32'd0);
        reset = 1'b0;
        forceOut = 1'b1;
        repeat (3) @(negedge clk);
        checkState();

        l0 = launchCount;
        applyStimulus(DIVU, 32'd100, 32'd7, st);
        applyStimulus(MFLO, 32'd0, 32'd0, st);
        checkOutput("mfloStalled", 32'(st >= 2), 32'd1);
        checkOutput("divuLo", lo, 32'd14);
        checkOutput("divuHi", hi, 32'd2);
        checkOutput("divuLaunchOnce", 32'(launchCount - l0), 32'd1);
        checkState();

        applyStimulus(DIV, 32'hFFFF_FFF9, 32'd2, st);
        checkOutput("divSrcA", divBus.SrcA, 32'd7);
        checkOutput("divSrcB", divBus.SrcB, 32'd2);
        waitIdle();
        checkOutput("divLo", lo, 32'hFFFF_FFFD);
        checkOutput("divHi", hi, 32'hFFFF_FFFF);

        applyStimulus(MULT, 32'hFFFF_FFFF, 32'd2, st);
        checkOutput("multHi", hi, 32'hFFFF_FFFF);
        checkOutput("multLo", lo, 32'hFFFF_FFFE);
        applyStimulus(MULTU, 32'hFFFF_FFFF, 32'd2, st);
        checkOutput("multuHi", hi, 32'h0000_0001);
        checkOutput("multuLo", lo, 32'hFFFF_FFFE);

        applyStimulus(MTHI, 32'h11, 32'd0, st);
        applyStimulus(MTLO, 32'h22, 32'd0, st);
        l0 = launchCount;
        applyStimulus(DIVU, 32'd5, 32'd0, st);
        @(negedge clk);
        checkOutput("div0Launch", 32'(launchCount - l0), 32'd0);
        checkOutput("div0Hi", hi, 32'h11);
        checkOutput("div0Lo", lo, 32'h22);
        checkState();

        applyStimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF, st);
        waitIdle();
        checkOutput("ovfLo", lo, 32'h8000_0000);
        checkOutput("ovfHi", hi, 32'd0);
        applyStimulus(MTHI, 32'hABCD, 32'd0, st);
        applyStimulus(MFHI, 32'd0, 32'd0, st);
        checkOutput("mthiVal", hi, 32'hABCD);

        applyStimulus(MTHI, 32'h55, 32'd0, st);
        applyStimulus(MTLO, 32'h66, 32'd0, st);
        dlyMin = 6;
        dlyMax = 6;
        applyStimulus(DIV, 32'd1000, 32'd3, st);
        @(negedge clk);
        checkOutput("waitBusy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        expHi = '0;
        expLo = '0;
        checkOutput("midRstHi", hi, 32'd0);
        checkOutput("midRstLo", lo, 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        forceOut = 1'b1;
        repeat (3) @(negedge clk);
        checkState();
        dlyMin = 0;
        dlyMax = 4;
        expLaunch = launchCount;

        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(7, 0));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(9, 0))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(200, 0)); b = 32'($urandom_range(15, 1)); end
                3: b = -32'($urandom_range(15, 1));
                default: ;
            endcase
            applyStimulus(o, a, b, st);
            if ($urandom_range(1, 0) == 1) begin
                waitIdle();
                checkState();
            end
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        waitIdle();
        checkState();
        checkOutput("launchTotal", 32'(launchCount), 32'(expLaunch));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- HI/LO register unit for the MIPS core. Executes MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO.
- Acts as the initiator side of the Div handshake:
  - drives the divider's validIn, SrcA and SrcB;
  - consumes its validOut, Hi and Lo.
- Multiplies complete in one cycle. Divides are multi-cycle. The unit stalls the pipeline while a divide is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO register width. The divider interface is fixed at 32.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  HI/LO instruction present this cycle.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6=MFHI 7=MFLO.
- rs_val  in  32  rs operand (dividend, multiplicand, MT source).
- rt_val  in  32  rt operand (divisor, multiplier).
- stall  out  1  combinational; = op_valid && busy.
- rd_data  out  32  combinational; HI for op=6, LO for op=7, otherwise 0.
- busy  out  1  divide in flight.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- div_validIn  out  1  one-cycle start pulse to the divider.
- div_SrcA  out  32  dividend magnitude, held stable while busy.
- div_SrcB  out  32  divisor magnitude, held stable while busy.
- div_validOut  in  1  divider done pulse.
- div_Hi  in  32  divider quotient.
- div_Lo  in  32  divider remainder.

Behaviour:
- Reset values: state IDLE; hi=0; lo=0; busy=0; div_validIn=0; div_SrcA=0; div_SrcB=0; sign flags=0.
- Accept rule: an op is accepted on a rising edge where op_valid=1 and stall=0. No op is accepted while busy, including MF, MT and multiplies.
- MULT: {hi,lo} <= signed 64-bit product rs_val*rt_val, written on the accept edge.
- MULTU: as MULT, but the product is unsigned.
- MTHI: hi <= rs_val on the accept edge.
- MTLO: lo <= rs_val on the accept edge.
- MFHI/MFLO: rd_data reflects the current register. An MT accepted at edge N is visible to an MF in cycle N+1.
- DIVU/DIV with rt_val=0:
  - completes on the accept edge;
  - hi and lo unchanged;
  - div_validIn never pulses; busy stays 0.
- DIVU with rt_val≠0:
  - latch div_SrcA=rs_val and div_SrcB=rt_val;
  - clear both sign flags;
  - go to LAUNCH.
- DIV with rt_val≠0:
  - latch the magnitudes |rs_val| and |rt_val|. |0x80000000| = 0x80000000, treated as unsigned;
  - qneg = rs[31]^rt[31];
  - rneg = rs[31];
  - go to LAUNCH.
- State machine:
  - IDLE: accepts ops as above. busy=0.
  - LAUNCH: div_validIn=1 for exactly this one cycle; busy=1; next WAIT.
  - WAIT: busy=1; div_SrcA and div_SrcB held, since the divider re-reads SrcB every cycle. On div_validOut=1, the same edge writes:
    - lo <= qneg ? -div_Hi : div_Hi (quotient);
    - hi <= rneg ? -div_Lo : div_Lo (remainder);
    - next state IDLE; busy drops the cycle after the validOut pulse.
- Result mapping: the divider's Hi is the quotient and goes to LO; the divider's Lo is the remainder and goes to HI. Architectural MIPS ordering.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
- div_validOut is ignored outside WAIT. This covers stale pulses after reset, since the divider has no reset.
- Reset mid-divide:
  - immediate return to IDLE; hi=0, lo=0, busy=0;
  - any later div_validOut is ignored.
- Latency: DIV/DIVU occupy 2 + D cycles, where D is the number of cycles from div_validIn to div_validOut. stall is asserted throughout.

Test Plan:
- DIVU: rs=100, rt=7, then MFLO presented immediately → stall=1 until busy falls. Then lo=14, hi=2 and rd_data=14. div_validIn pulses exactly once.
- DIV: rs=0xFFFFFFF9 (-7), rt=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). div_SrcA=7 and div_SrcB=2 stable through WAIT.
- Multiplies with rs=0xFFFFFFFF, rt=2:
  - MULT → hi=0xFFFFFFFF, lo=0xFFFFFFFE in one cycle, busy=0;
  - MULTU → hi=0x00000001, lo=0xFFFFFFFE.
- Divide by zero: preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIVU 5/0 → hi=0x11, lo=0x22, no div_validIn, stall never asserted.
- Overflow plus back-to-back: DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. Then MTHI 0xABCD followed next cycle by MFHI → rd_data=0xABCD.
- Reset in WAIT: assert reset mid-divide → hi=lo=0, busy=0 immediately. Inject div_validOut=1 afterwards → hi/lo stay 0, state stays IDLE.
